// File: rtl/seq_alu.sv
// seq_alu: multi-cycle 4-op ALU (add/sub/mul/div) with operand modifier and
// valid/ready handshakes on both sides. Radix-2 iterative mul and restoring div.
// Optional build macro ALU_REMAINDER_EN: drives the remainder into the upper
// half of a divide result (undefined: upper half of a divide result is zero).
module seq_alu #(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         control,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               div_by_zero,
  output logic               busy
);

  localparam int unsigned OW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic            r_dbz;
  logic [OW-1:0]   r_out;
  // Shared iteration registers: mul uses acc/multiplicand/multiplier,
  // div uses acc[WIDTH-1:0] as partial remainder, opnd as divisor,
  // shf as dividend shifting out / quotient shifting in.
  logic [OW-1:0]   r_acc;
  logic [OW-1:0]   r_opnd;
  logic [WIDTH-1:0] r_shf;
  logic [CW-1:0]   r_cnt;
  logic            r_is_div;

  logic [WIDTH-1:0] w_ia;
  logic [OW-1:0]    w_a_ext;
  logic [OW-1:0]    w_b_ext;
  logic             w_accept;
  logic [OW-1:0]    w_mul_acc_nxt;
  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_rem_diff;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic             w_last;

  // Operand modifier applied to A
  always_comb begin
    w_ia = a;
    case (control[1:0])
      2'b00:   w_ia = a;
      2'b01:   w_ia = {1'b0, a[WIDTH-2:0]};
      2'b10:   w_ia = {a[WIDTH-1:1], 1'b0};
      default: w_ia = a & b;
    endcase
  end

  assign w_a_ext  = {{WIDTH{1'b0}}, w_ia};
  assign w_b_ext  = {{WIDTH{1'b0}}, b};
  assign w_accept = in_valid && r_in_ready;

  assign w_mul_acc_nxt = r_shf[0] ? (r_acc + r_opnd) : r_acc;

  assign w_rem_shift = {r_acc[WIDTH-1:0], r_shf[WIDTH-1]};
  assign w_rem_diff  = w_rem_shift - {1'b0, r_opnd[WIDTH-1:0]};
  assign w_div_ok    = !w_rem_diff[WIDTH];
  assign w_rem_nxt   = w_div_ok ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
  assign w_quo_nxt   = {r_shf[WIDTH-2:0], w_div_ok};
  assign w_last      = (r_cnt == CW'(WIDTH - 1));

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_dbz       <= 1'b0;
      r_out       <= '0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_shf       <= '0;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            case (control[3:2])
              OP_ADD: begin
                r_out       <= w_a_ext + w_b_ext;
                r_dbz       <= 1'b0;
                r_out_valid <= 1'b1;
                r_state     <= DONE;
              end
              OP_SUB: begin
                r_out       <= w_a_ext - w_b_ext;
                r_dbz       <= 1'b0;
                r_out_valid <= 1'b1;
                r_state     <= DONE;
              end
              OP_MUL: begin
                r_acc    <= '0;
                r_opnd   <= w_a_ext;
                r_shf    <= b;
                r_cnt    <= '0;
                r_is_div <= 1'b0;
                r_state  <= CALC;
              end
              default: begin
                if (b == '0) begin
`ifdef ALU_REMAINDER_EN
                  r_out <= {w_ia, {WIDTH{1'b1}}};
`else
                  r_out <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
`endif
                  r_dbz       <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
                end else begin
                  r_acc    <= '0;
                  r_opnd   <= w_b_ext;
                  r_shf    <= w_ia;
                  r_cnt    <= '0;
                  r_is_div <= 1'b1;
                  r_state  <= CALC;
                end
              end
            endcase
          end
        end
        CALC: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_is_div) begin
            r_acc[WIDTH-1:0] <= w_rem_nxt;
            r_shf            <= w_quo_nxt;
          end else begin
            r_acc  <= w_mul_acc_nxt;
            r_opnd <= r_opnd << 1;
            r_shf  <= r_shf >> 1;
          end
          if (w_last) begin
            if (r_is_div) begin
`ifdef ALU_REMAINDER_EN
              r_out <= {w_rem_nxt, w_quo_nxt};
`else
              r_out <= {{WIDTH{1'b0}}, w_quo_nxt};
`endif
            end else begin
              r_out <= w_mul_acc_nxt;
            end
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign div_by_zero = r_dbz;
  assign out         = r_out;

endmodule
